// File: rtl/gcd_sweep_ctrl_pkg.sv
// Shared definitions for the GCD operand sweep controller: one-hot state
// encoding and a small decode helper.
package gcd_sweep_ctrl_pkg;

   typedef enum logic [8:0] {
      S_IDLE      = 9'h001,
      S_LOAD      = 9'h002,
      S_START     = 9'h004,
      S_WAIT_SUB  = 9'h008,
      S_WAIT_DONE = 9'h010,
      S_ACK       = 9'h020,
      S_EMIT      = 9'h040,
      S_NEXT      = 9'h080,
      S_FIN       = 9'h100
   } state_e;

   function automatic logic is_busy(input state_e s);
      return s != S_IDLE;
   endfunction

endpackage

// File: rtl/gcd_sweep_ctrl_if.sv
// Core handshake plus result record stream between the sweep controller
// (master) and the GCD core / downstream logger (slave).
interface gcd_sweep_ctrl_if #(
   parameter int W     = 8,
   parameter int CNT_W = 16
);
   logic [W-1:0]     Ain;
   logic [W-1:0]     Bin;
   logic             Start;
   logic             Ack;
   logic             q_Sub;
   logic             q_Done;
   logic [W-1:0]     AB_GCD;
   logic             Res_Valid;
   logic             Res_Ready;
   logic [W-1:0]     Res_A;
   logic [W-1:0]     Res_B;
   logic [W-1:0]     Res_GCD;
   logic [CNT_W-1:0] Res_Clks;

   modport master (
      output Ain, Bin, Start, Ack, Res_Valid, Res_A, Res_B, Res_GCD, Res_Clks,
      input  q_Sub, q_Done, AB_GCD, Res_Ready
   );

   modport slave (
      input  Ain, Bin, Start, Ack, Res_Valid, Res_A, Res_B, Res_GCD, Res_Clks,
      output q_Sub, q_Done, AB_GCD, Res_Ready
   );
endinterface

// File: rtl/gcd_sweep_ctrl_stepper.sv
// Operand grid walker: B is the inner loop, A the outer; flags the last pair.
module gcd_sweep_ctrl_stepper #(
   parameter int W     = 8,
   parameter int A_MIN = 2,
   parameter int A_MAX = 63,
   parameter int B_MIN = 2,
   parameter int B_MAX = 63
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         CEN,
   input  logic         init,
   input  logic         step,
   output logic [W-1:0] a,
   output logic [W-1:0] b,
   output logic         last
);

   localparam logic [W-1:0] A_LO = W'(A_MIN);
   localparam logic [W-1:0] A_HI = W'(A_MAX);
   localparam logic [W-1:0] B_LO = W'(B_MIN);
   localparam logic [W-1:0] B_HI = W'(B_MAX);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         a <= '0;
         b <= '0;
      end else if (CEN) begin
         if (init) begin
            a <= A_LO;
            b <= B_LO;
         end else if (step) begin
            if (b == B_HI) begin
               b <= B_LO;
               a <= a + 1'b1;
            end else begin
               b <= b + 1'b1;
            end
         end
      end
   end

   assign last = (a == A_HI) && (b == B_HI);

endmodule

// File: rtl/gcd_sweep_ctrl.sv
// Sweeps (Ain,Bin) over a grid, runs each pair through the GCD core's
// Start/Ack handshake, times q_Sub->q_Done and emits one record per pair.
module gcd_sweep_ctrl
   import gcd_sweep_ctrl_pkg::*;
#(
   parameter int W     = 8,
   parameter int CNT_W = 16,
   parameter int A_MIN = 2,
   parameter int A_MAX = 63,
   parameter int B_MIN = 2,
   parameter int B_MAX = 63
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             CEN,
   input  logic             Go,
   input  logic             Abort,
   gcd_sweep_ctrl_if.master bus,
   output logic [CNT_W-1:0] Max_Clks,
   output logic             Busy,
   output logic             Sweep_Done
);

   state_e           state, state_nxt;
   logic             abort_q, abort_seen;
   logic             init, step, last;
   logic [W-1:0]     a_cur, b_cur, gcd_cap;
   logic [W-1:0]     res_a, res_b, res_gcd;
   logic [CNT_W-1:0] cnt, res_clks, max_clks;

   gcd_sweep_ctrl_stepper #(
      .W(W), .A_MIN(A_MIN), .A_MAX(A_MAX), .B_MIN(B_MIN), .B_MAX(B_MAX)
   ) u_stepper (
      .Clk(Clk), .Reset_n(Reset_n), .CEN(CEN),
      .init(init), .step(step), .a(a_cur), .b(b_cur), .last(last)
   );

   // A live Abort counts immediately so Start is suppressed in the same cycle.
   assign abort_seen = abort_q | Abort;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= S_IDLE;
         abort_q <= 1'b0;
      end else if (CEN) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state   <= state_nxt;
         abort_q <= (state == S_IDLE) ? 1'b0 : (abort_q | Abort);
      end
   end

   always_comb begin
      // NOTE: defaults first so no branch leaves a signal unassigned (no latches).
      state_nxt     = state;
      init          = 1'b0;
      step          = 1'b0;
      bus.Start     = 1'b0;
      bus.Ack       = 1'b0;
      bus.Res_Valid = 1'b0;
      case (state)
         S_IDLE: if (Go && !Abort) begin
            state_nxt = S_LOAD;
            init      = 1'b1;
         end
         S_LOAD:  state_nxt = abort_seen ? S_IDLE : S_START;
         S_START: begin
            bus.Start = !abort_seen;
            state_nxt = abort_seen ? S_IDLE : S_WAIT_SUB;
         end
         S_WAIT_SUB: begin
            if (bus.q_Done)     state_nxt = S_ACK;
            else if (bus.q_Sub) state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: if (bus.q_Done) state_nxt = S_ACK;
         S_ACK: begin
            bus.Ack   = 1'b1;
            state_nxt = abort_seen ? S_IDLE : S_EMIT;
         end
         S_EMIT: begin
            bus.Res_Valid = 1'b1;
            if (bus.Res_Ready) state_nxt = abort_seen ? S_IDLE : S_NEXT;
         end
         S_NEXT: begin
            if (abort_seen) state_nxt = S_IDLE;
            else if (last)  state_nxt = S_FIN;
            else begin
               step      = 1'b1;
               state_nxt = S_LOAD;
            end
         end
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt      <= '0;
         gcd_cap  <= '0;
         res_a    <= '0;
         res_b    <= '0;
         res_gcd  <= '0;
         res_clks <= '0;
         max_clks <= '0;
      end else if (CEN) begin
         case (state)
            S_IDLE: if (Go && !Abort) max_clks <= '0;
            S_WAIT_SUB: begin
               if (bus.q_Done) begin
                  gcd_cap <= bus.AB_GCD;
                  cnt     <= '0;
               end else if (bus.q_Sub) begin
                  cnt <= '0;
               end
            end
            S_WAIT_DONE: begin
               if (bus.q_Done)              gcd_cap <= bus.AB_GCD;
               else if (cnt != {CNT_W{1'b1}}) cnt   <= cnt + 1'b1;
            end
            // Discarded (aborted) operations never reach the record or the maximum.
            S_ACK: if (!abort_seen) begin
               res_a    <= a_cur;
               res_b    <= b_cur;
               res_gcd  <= gcd_cap;
               res_clks <= cnt;
               if (cnt > max_clks) max_clks <= cnt;
            end
            default: ;
         endcase
      end
   end

   assign bus.Ain      = a_cur;
   assign bus.Bin      = b_cur;
   assign bus.Res_A    = res_a;
   assign bus.Res_B    = res_b;
   assign bus.Res_GCD  = res_gcd;
   assign bus.Res_Clks = res_clks;
   assign Max_Clks     = max_clks;
   assign Busy         = is_busy(state);
   assign Sweep_Done   = (state == S_FIN);

endmodule

// File: tb/tb_gcd_sweep_ctrl.sv
// Bench for gcd_sweep_ctrl: subtractive GCD core stub, queue-based record model,
// directed latency/abort/reset runs, random CEN/backpressure, and a saturation DUT.
module tb_gcd_sweep_ctrl;
   localparam int W = 8, CNT_W = 16;
   localparam int A_MIN = 2, A_MAX = 6, B_MIN = 2, B_MAX = 6;
   localparam int N_PAIRS = (A_MAX - A_MIN + 1) * (B_MAX - B_MIN + 1);

   typedef struct packed {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  g;
      logic [15:0] c;
   } rec_t;

   logic Clk = 1'b0;
   logic Reset_n, CEN, Go, Abort, Go2;
   logic rand_mode;
   logic [CNT_W-1:0] Max_Clks;
   logic Busy, Sweep_Done;
   logic [3:0] Max_Clks2;
   logic Busy2, Sweep_Done2;

   int n_checks = 0, n_errors = 0;
   int start_cnt = 0, ack_cnt = 0, done_cnt = 0;
   rec_t exp_q[$];
   int exp_max;

   gcd_sweep_ctrl_if #(.W(W), .CNT_W(CNT_W)) bus ();
   gcd_sweep_ctrl_if #(.W(W), .CNT_W(4))     bus2 ();

   always #5 Clk = ~Clk;

   gcd_sweep_ctrl #(
      .W(W), .CNT_W(CNT_W), .A_MIN(A_MIN), .A_MAX(A_MAX), .B_MIN(B_MIN), .B_MAX(B_MAX)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .CEN(CEN), .Go(Go), .Abort(Abort),
      .bus(bus), .Max_Clks(Max_Clks), .Busy(Busy), .Sweep_Done(Sweep_Done)
   );

   gcd_sweep_ctrl #(
      .W(W), .CNT_W(4), .A_MIN(3), .A_MAX(3), .B_MIN(9), .B_MAX(9)
   ) dut_sat (
      .Clk(Clk), .Reset_n(Reset_n), .CEN(1'b1), .Go(Go2), .Abort(1'b0),
      .bus(bus2), .Max_Clks(Max_Clks2), .Busy(Busy2), .Sweep_Done(Sweep_Done2)
   );

   // Subtractive GCD core stub; equal operands take the straight-to-done shortcut.
   typedef enum logic [1:0] {C_I, C_SUB, C_DONE} core_e;
   core_e core_st;
   logic [7:0] ca, cb;
   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         core_st <= C_I; ca <= '0; cb <= '0;
      end else if (CEN) begin
         case (core_st)
            C_I: if (bus.Start) begin
               ca <= bus.Ain; cb <= bus.Bin;
               core_st <= (bus.Ain == bus.Bin) ? C_DONE : C_SUB;
            end
            C_SUB: begin
               if (ca == cb)     core_st <= C_DONE;
               else if (ca > cb) ca <= ca - cb;
               else              cb <= cb - ca;
            end
            C_DONE: if (bus.Ack) core_st <= C_I;
            default: core_st <= C_I;
         endcase
      end
   end
   assign bus.q_Sub  = (core_st == C_SUB);
   assign bus.q_Done = (core_st == C_DONE);
   assign bus.AB_GCD = ca;

   // Slow stub for the saturation DUT: q_Sub held for 20 cycles, result 7.
   logic [1:0] s2_st;
   int s2_cnt;
   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s2_st <= 2'd0; s2_cnt <= 0;
      end else begin
         case (s2_st)
            2'd0: if (bus2.Start) begin s2_st <= 2'd1; s2_cnt <= 0; end
            2'd1: if (s2_cnt == 19) s2_st <= 2'd2; else s2_cnt <= s2_cnt + 1;
            2'd2: if (bus2.Ack) s2_st <= 2'd0;
            default: s2_st <= 2'd0;
         endcase
      end
   end
   assign bus2.q_Sub     = (s2_st == 2'd1);
   assign bus2.q_Done    = (s2_st == 2'd2);
   assign bus2.AB_GCD    = 8'd7;
   assign bus2.Res_Ready = 1'b1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: Res_Clks equals the number of subtraction steps the core performs.
   function automatic void ref_pair(input int a, input int b, output int g, output int s);
      s = 0;
      while (a != b) begin
         if (a > b) a -= b; else b -= a;
         s++;
      end
      g = a;
   endfunction

   task automatic build_exp(input int a_end, input int b_end);
      int g, s;
      rec_t r;
      exp_q.delete();
      exp_max = 0;
      for (int a = A_MIN; a <= A_MAX; a++)
         for (int b = B_MIN; b <= B_MAX; b++) begin
            if (a == a_end && b == b_end) return;
            ref_pair(a, b, g, s);
            r.a = 8'(a); r.b = 8'(b); r.g = 8'(g);
            r.c = 16'((s > 65535) ? 65535 : s);
            exp_q.push_back(r);
            if (s > exp_max) exp_max = s;
         end
   endtask

   // Record monitor: in-order scoreboard, EMIT stability, enabled-cycle pulse counts.
   logic [39:0] cur;
   logic [39:0] hold_word;
   logic hold_valid;
   assign cur = {bus.Res_A, bus.Res_B, bus.Res_GCD, bus.Res_Clks};
   always @(negedge Clk) begin
      rec_t r;
      if (!Reset_n) begin
         hold_valid = 1'b0;
      end else begin
         if (CEN && bus.Start) start_cnt++;
         if (CEN && bus.Ack)   ack_cnt++;
         if (CEN && Sweep_Done) done_cnt++;
         if (bus.Res_Valid) begin
            check("no_start_in_emit", 64'(bus.Start), 64'(0));
            if (hold_valid) check("res_stable", 64'(cur), 64'(hold_word));
         end else if (hold_valid) begin
            check("valid_held", 64'(bus.Res_Valid), 64'(1));
         end
         if (CEN && bus.Res_Valid && bus.Res_Ready) begin
            check("record_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               r = exp_q.pop_front();
               check("record", 64'(cur), 64'(r));
            end
         end
         hold_valid = bus.Res_Valid && !(CEN && bus.Res_Ready);
         hold_word  = cur;
      end
   end

   initial begin
      CEN = 1'b1; bus.Res_Ready = 1'b1;
      forever begin
         @(posedge Clk);
         #1;
         if (rand_mode) begin
            CEN           = ($urandom_range(0, 1) == 1);
            bus.Res_Ready = ($urandom_range(0, 2) != 0);
         end
      end
   end

   task automatic check_idle(input string tag);
      check({tag, "_ctl"}, 64'({Busy, Sweep_Done, bus.Start, bus.Ack, bus.Res_Valid}), 64'(0));
      check({tag, "_data"}, 64'({bus.Ain, bus.Bin, bus.Res_A, bus.Res_B, bus.Res_GCD}), 64'(0));
      check({tag, "_cnt"}, 64'({bus.Res_Clks, Max_Clks}), 64'(0));
   endtask

   task automatic start_sweep(input string tag, input int extra);
      int n = 0;
      Go = 1'b1;
      while (!Busy && n < 100) begin @(negedge Clk); n++; end
      check({tag, "_taken"}, 64'(Busy), 64'(1));
      repeat (extra) @(negedge Clk);
      Go = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int d0, input int budget);
      int n = 0;
      while (done_cnt == d0 && n < budget) begin @(negedge Clk); n++; end
      #1;
      check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (Busy && n < 500) begin @(negedge Clk); n++; end
      check({tag, "_idle"}, 64'(Busy), 64'(0));
   endtask

   task automatic wait_pair(input string tag, input int a, input int b);
      int n = 0;
      while (!(bus.q_Sub && bus.Ain == 8'(a) && bus.Bin == 8'(b)) && n < 3000) begin
         @(negedge Clk); n++;
      end
      check({tag, "_pair_reached"}, 64'(bus.q_Sub), 64'(1));
   endtask

   initial begin
      int d0, s0, a0, n;
      Reset_n = 1'b1; Go = 1'b0; Abort = 1'b0; Go2 = 1'b0; rand_mode = 1'b0;
      #2 Reset_n = 1'b0;
      #1 check_idle("reset");
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      // Full sweep, CEN=1, always ready; includes Go->Start latency.
      build_exp(A_MAX + 1, 0);
      d0 = done_cnt; s0 = start_cnt;
      Go = 1'b1;
      @(negedge Clk);
      check("busy_after_go", 64'(Busy), 64'(1));
      check("no_start_in_load", 64'(bus.Start), 64'(0));
      Go = 1'b0;
      @(negedge Clk);
      check("start_latency", 64'(bus.Start), 64'(1));
      check("first_pair", 64'({bus.Ain, bus.Bin}), 64'({8'(A_MIN), 8'(B_MIN)}));
      wait_done("sweep1", d0, 3000);
      wait_idle("sweep1");
      check("sweep1_drained", 64'(exp_q.size()), 64'(0));
      check("sweep1_max", 64'(Max_Clks), 64'(exp_max));
      check("sweep1_last_pair", 64'({bus.Ain, bus.Bin}), 64'({8'(A_MAX), 8'(B_MAX)}));
      check("sweep1_starts", 64'(start_cnt - s0), 64'(N_PAIRS));

      // Random CEN and backpressure; Go held while busy must not restart.
      build_exp(A_MAX + 1, 0);
      d0 = done_cnt;
      rand_mode = 1'b1;
      start_sweep("rand_go", 6);
      wait_done("rand", d0, 20000);
      wait_idle("rand");
      rand_mode = 1'b0;
      CEN = 1'b1; bus.Res_Ready = 1'b1;
      @(negedge Clk);
      check("rand_drained", 64'(exp_q.size()), 64'(0));
      check("rand_max", 64'(Max_Clks), 64'(exp_max));

      // Abort during WAIT_DONE of (4,6): Ack still issued, record discarded.
      build_exp(4, 6);
      d0 = done_cnt;
      start_sweep("abort_go", 0);
      wait_pair("abort", 4, 6);
      @(negedge Clk);
      Abort = 1'b1;
      a0 = ack_cnt;
      @(negedge Clk);
      Abort = 1'b0;
      wait_idle("abort");
      repeat (2) @(negedge Clk);
      check("abort_ack_pulses", 64'(ack_cnt - a0), 64'(1));
      check("abort_prior_records", 64'(exp_q.size()), 64'(0));
      check("abort_no_sweep_done", 64'(done_cnt - d0), 64'(0));
      check("abort_core_idle", 64'(core_st), 64'(C_I));
      check("abort_no_valid", 64'(bus.Res_Valid), 64'(0));

      // Reset in the middle of an operation, then a clean restart.
      build_exp(A_MAX + 1, 0);
      start_sweep("reset_go", 0);
      wait_pair("mid_reset", 3, 5);
      @(negedge Clk);
      Reset_n = 1'b0;
      #1 check_idle("mid_reset");
      check("mid_reset_core", 64'(core_st), 64'(C_I));
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      build_exp(A_MAX + 1, 0);
      d0 = done_cnt;
      start_sweep("restart_go", 0);
      n = 0;
      while (!bus.Start && n < 10) begin @(negedge Clk); n++; end
      check("restart_start", 64'(bus.Start), 64'(1));
      check("restart_pair", 64'({bus.Ain, bus.Bin}), 64'({8'(A_MIN), 8'(B_MIN)}));
      wait_done("restart", d0, 3000);
      wait_idle("restart");
      check("restart_drained", 64'(exp_q.size()), 64'(0));
      check("restart_max", 64'(Max_Clks), 64'(exp_max));

      // Saturating counter: 4-bit width against a 20-cycle q_Sub.
      Go2 = 1'b1;
      @(negedge Clk);
      Go2 = 1'b0;
      n = 0;
      while (!bus2.Res_Valid && n < 200) begin @(negedge Clk); n++; end
      check("sat_valid", 64'(bus2.Res_Valid), 64'(1));
      check("sat_clks", 64'(bus2.Res_Clks), 64'(15));
      check("sat_record", 64'({bus2.Res_A, bus2.Res_B, bus2.Res_GCD}), 64'({8'd3, 8'd9, 8'd7}));
      n = 0;
      while (!Sweep_Done2 && n < 50) begin @(negedge Clk); n++; end
      check("sat_sweep_done", 64'(Sweep_Done2), 64'(1));
      check("sat_max", 64'(Max_Clks2), 64'(15));
      @(negedge Clk);
      check("sat_idle", 64'(Busy2), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
